// File: rtl/video_mono_tint_fader_if.sv
// rtl/video_mono_tint_fader_if.sv - pixel/mode bundle between pixel generator and tint fader
// Purpose: groups the pixel-rate signals of the mono/tint fader.
// Ports (signals):
//   ce_pix, vblank, hblank   pixel enable and blanking, aligned with R/G/B
//   gfx_mode[2:0]            requested display mode
//   R, G, B [DW-1:0]         input pixel
//   R_OUT, G_OUT, B_OUT      output pixel
//   active_mode[2:0]         mode currently displayed
//   fading                   fade sequence in progress
// Modports: master = pixel source/observer, slave = fader.
interface video_mono_tint_fader_if #(
    parameter int DW = 8
);
    logic          ce_pix;
    logic          vblank;
    logic          hblank;
    logic [2:0]    gfx_mode;
    logic [DW-1:0] R;
    logic [DW-1:0] G;
    logic [DW-1:0] B;
    logic [DW-1:0] R_OUT;
    logic [DW-1:0] G_OUT;
    logic [DW-1:0] B_OUT;
    logic [2:0]    active_mode;
    logic          fading;

    modport master (
        output ce_pix, vblank, hblank, gfx_mode, R, G, B,
        input  R_OUT, G_OUT, B_OUT, active_mode, fading
    );

    modport slave (
        input  ce_pix, vblank, hblank, gfx_mode, R, G, B,
        output R_OUT, G_OUT, B_OUT, active_mode, fading
    );
endinterface

// File: rtl/video_mono_tint_fader.sv
// rtl/video_mono_tint_fader.sv - parametrised luma/tint converter with frame-synchronous crossfade
// Purpose: 3-stage pipeline computing luma from RGB, mapping it to one of eight
//          colour/tint modes and scaling by a fade gain. Mode switches happen only
//          at vertical blank edges, as a fade-out/fade-in over 2^FADE_LOG2 frames.
// Ports:
//   clk_vid   video clock
//   reset_n   asynchronous active-low reset
//   vif       slave side of video_mono_tint_fader_if (pixel in/out, mode, status)
module video_mono_tint_fader #(
    parameter int DW        = 8,
    parameter int KR        = 13933,
    parameter int KG        = 46871,
    parameter int KB        = 4732,
    parameter int FADE_LOG2 = 2
) (
    input  logic                     clk_vid,
    input  logic                     reset_n,
    video_mono_tint_fader_if.slave   vif
);

    localparam int            GW    = FADE_LOG2 + 1;
    localparam int            PW    = DW + GW;
    localparam logic [GW-1:0] GMAX  = GW'(1 << FADE_LOG2);
    localparam logic [31:0]   KR_C  = 32'(KR);
    localparam logic [31:0]   KG_C  = 32'(KG);
    localparam logic [31:0]   KB_C  = 32'(KB);
    localparam logic [15:0]   MAXW  = 16'((1 << DW) - 1);
    localparam logic [DW-1:0] F15   = DW'(15 << (DW - 8));
    localparam logic [DW-1:0] F8    = DW'(8 << (DW - 8));
    localparam logic [DW-1:0] ONE   = DW'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        FADE_IN  = 2'd2
    } state_t;

    // S1
    logic [DW-1:0] r1_q, g1_q, b1_q;
    logic          blank1_q, vb1_q, vb1_prev_q;
    // S2
    logic [DW-1:0] r2_q, g2_q, b2_q, mono2_q, half2_q;
    logic          blank2_q;
    // S3
    logic [DW-1:0] ro_q, go_q, bo_q;

    logic [2:0]    target_q;
    logic [2:0]    active_q, active_d;
    logic [GW-1:0] gain_q, gain_d;
    state_t        state_q, state_d;

    logic          fe;
    logic [31:0]   acc;
    logic [15:0]   mono_raw;
    logic [DW-1:0] mono_d;
    logic [DW-1:0] fl8, fl15;
    logic [DW-1:0] tr, tg, tb;
    logic [DW-1:0] ro_d, go_d, bo_d;

    // Product cannot overflow: tint < 2^DW and gain <= 2^FADE_LOG2.
    function automatic logic [DW-1:0] scale(input logic [DW-1:0] t, input logic [GW-1:0] g);
        logic [PW-1:0] p;
        p = {{GW{1'b0}}, t} * {{DW{1'b0}}, g};
        return DW'(p >> FADE_LOG2);
    endfunction

    // Frame edge: first enabled pixel after S1 vblank rose.
    assign fe = vif.ce_pix && vb1_q && !vb1_prev_q;

    always_comb begin
        acc      = KR_C * 32'(r1_q) + KG_C * 32'(g1_q) + KB_C * 32'(b1_q) + 32'd32768;
        mono_raw = 16'(acc >> 16);
        mono_d   = (mono_raw > MAXW) ? {DW{1'b1}} : mono_raw[DW-1:0];
    end

    always_comb begin
        fl8  = (mono2_q > F8)  ? mono2_q : F8;
        fl15 = (mono2_q > F15) ? mono2_q : F15;
        tr   = r2_q;
        tg   = g2_q;
        tb   = b2_q;
        case (active_q)
            3'b001: begin tr = '0;      tg = fl15;    tb = ONE;     end
            3'b010: begin tr = fl8;     tg = half2_q; tb = ONE;     end
            3'b011: begin tr = mono2_q; tg = mono2_q; tb = mono2_q; end
            3'b100: begin tr = '0;      tg = half2_q; tb = fl8;     end
            3'b101: begin tr = fl8;     tg = '0;      tb = ONE;     end
            3'b110: begin tr = fl8;     tg = '0;      tb = half2_q; end
            3'b111: begin tr = half2_q; tg = '0;      tb = fl8;     end
            default: ;
        endcase
        if (blank2_q) begin
            ro_d = '0;
            go_d = '0;
            bo_d = '0;
        end else begin
            ro_d = scale(tr, gain_q);
            go_d = scale(tg, gain_q);
            bo_d = scale(tb, gain_q);
        end
    end

    always_comb begin
        state_d  = state_q;
        gain_d   = gain_q;
        active_d = active_q;
        if (fe) begin
            case (state_q)
                IDLE: begin
                    if (target_q != active_q) begin
                        if (FADE_LOG2 == 0) begin
                            active_d = target_q;
                        end else begin
                            gain_d  = gain_q - 1'b1;
                            state_d = FADE_OUT;
                        end
                    end
                end
                FADE_OUT: begin
                    if (target_q == active_q) begin
                        // Reverted: climb back; if already one step below full, done.
                        gain_d  = gain_q + 1'b1;
                        state_d = (gain_d == GMAX) ? IDLE : FADE_IN;
                    end else begin
                        gain_d = gain_q - 1'b1;
                        if (gain_d == '0) begin
                            active_d = target_q;
                            state_d  = FADE_IN;
                        end
                    end
                end
                FADE_IN: begin
                    if (target_q != active_q) begin
                        if (gain_q == '0) begin
                            // Already black: swap mode directly without underflowing gain.
                            active_d = target_q;
                        end else begin
                            gain_d  = gain_q - 1'b1;
                            state_d = FADE_OUT;
                        end
                    end else begin
                        gain_d = gain_q + 1'b1;
                        if (gain_d == GMAX) state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    gain_d  = GMAX;
                end
            endcase
        end
    end

    always_ff @(posedge clk_vid or negedge reset_n) begin
        if (!reset_n) begin
            r1_q       <= '0;
            g1_q       <= '0;
            b1_q       <= '0;
            blank1_q   <= 1'b0;
            vb1_q      <= 1'b0;
            vb1_prev_q <= 1'b0;
            r2_q       <= '0;
            g2_q       <= '0;
            b2_q       <= '0;
            mono2_q    <= '0;
            half2_q    <= '0;
            blank2_q   <= 1'b0;
            ro_q       <= '0;
            go_q       <= '0;
            bo_q       <= '0;
            target_q   <= 3'b000;
            active_q   <= 3'b000;
            gain_q     <= GMAX;
            state_q    <= IDLE;
        end else begin
            state_q  <= state_d;
            gain_q   <= gain_d;
            active_q <= active_d;
            if (vif.ce_pix) begin
                r1_q       <= vif.R;
                g1_q       <= vif.G;
                b1_q       <= vif.B;
                blank1_q   <= vif.vblank | vif.hblank;
                vb1_q      <= vif.vblank;
                vb1_prev_q <= vb1_q;
                r2_q       <= r1_q;
                g2_q       <= g1_q;
                b2_q       <= b1_q;
                mono2_q    <= mono_d;
                half2_q    <= mono_d >> 1;
                blank2_q   <= blank1_q;
                ro_q       <= ro_d;
                go_q       <= go_d;
                bo_q       <= bo_d;
                target_q   <= vif.gfx_mode;
            end
        end
    end

    assign vif.R_OUT       = ro_q;
    assign vif.G_OUT       = go_q;
    assign vif.B_OUT       = bo_q;
    assign vif.active_mode = active_q;
    assign vif.fading      = (state_q != IDLE);

endmodule

// File: tb/tb_video_mono_tint_fader.sv
// tb/tb_video_mono_tint_fader.sv - directed self-checking bench for video_mono_tint_fader
module tb_video_mono_tint_fader;

    logic clk_vid = 1'b0;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk_vid = ~clk_vid;

    video_mono_tint_fader_if #(.DW(8)) vif ();

    video_mono_tint_fader #(
        .DW(8), .KR(13933), .KG(46871), .KB(4732), .FADE_LOG2(2)
    ) dut (
        .clk_vid (clk_vid),
        .reset_n (reset_n),
        .vif     (vif.slave)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_vid);
            #1;
        end
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_rgb(input string tag, input int r, input int g, input int b);
        check({tag, ".R"}, int'(vif.R_OUT), r);
        check({tag, ".G"}, int'(vif.G_OUT), g);
        check({tag, ".B"}, int'(vif.B_OUT), b);
    endtask

    task automatic set_pix(input int r, input int g, input int b);
        vif.R = 8'(r);
        vif.G = 8'(g);
        vif.B = 8'(b);
    endtask

    // One frame: 2 pixels of vblank then 4 active pixels (enough to refill the pipeline).
    task automatic frame();
        vif.vblank = 1'b1;
        tick(2);
        vif.vblank = 1'b0;
        tick(4);
    endtask

    task automatic change_mode(input logic [2:0] m);
        vif.gfx_mode = m;
        for (int f = 0; f < 9; f++) frame();
        check("mode_switched", int'(vif.active_mode), int'(m));
        check("mode_idle", int'(vif.fading), 0);
    endtask

    int gains [8] = '{3, 2, 1, 0, 1, 2, 3, 4};
    int v;

    initial begin
        reset_n      = 1'b0;
        vif.ce_pix   = 1'b1;
        vif.vblank   = 1'b0;
        vif.hblank   = 1'b0;
        vif.gfx_mode = 3'b000;
        set_pix(255, 255, 255);
        tick(3);
        check_rgb("reset", 0, 0, 0);
        check("reset.active", int'(vif.active_mode), 0);
        check("reset.fading", int'(vif.fading), 0);
        reset_n = 1'b1;

        // Colour mode passes raw RGB at full gain.
        set_pix(8'h12, 8'h34, 8'h56);
        tick(3);
        check_rgb("colour_raw", 8'h12, 8'h34, 8'h56);
        vif.hblank = 1'b1;
        tick(3);
        check_rgb("hblank", 0, 0, 0);
        vif.hblank = 1'b0;

        // B&W
        set_pix(255, 255, 255);
        change_mode(3'b011);
        check_rgb("bw_white", 255, 255, 255);
        set_pix(255, 0, 0);
        tick(3);
        check_rgb("bw_red", 8'h36, 8'h36, 8'h36);
        set_pix(0, 0, 255);
        tick(3);
        check_rgb("bw_blue", 8'h12, 8'h12, 8'h12);

        // Green floor
        set_pix(0, 0, 0);
        change_mode(3'b001);
        check_rgb("green_black", 0, 15, 1);

        // Amber and ce_pix hold
        set_pix(255, 255, 255);
        change_mode(3'b010);
        check_rgb("amber_white", 255, 127, 1);
        vif.ce_pix = 1'b0;
        set_pix(0, 0, 0);
        vif.hblank = 1'b1;
        tick(5);
        check_rgb("ce_hold", 255, 127, 1);
        vif.ce_pix = 1'b1;
        vif.hblank = 1'b0;
        set_pix(255, 255, 255);

        // Crossfade green -> B&W
        change_mode(3'b001);
        check_rgb("green_white", 0, 255, 1);
        vif.gfx_mode = 3'b011;
        tick(3);
        check_rgb("midframe_nochange", 0, 255, 1);
        check("midframe_fading", int'(vif.fading), 0);
        for (int f = 0; f < 8; f++) begin
            frame();
            v = (255 * gains[f]) >> 2;
            if (f < 3) begin
                check_rgb($sformatf("fade%0d", f + 1), 0, v, gains[f] >> 2);
                check("fade_active", int'(vif.active_mode), 1);
            end else begin
                check_rgb($sformatf("fade%0d", f + 1), v, v, v);
                check("fade_active", int'(vif.active_mode), 3);
            end
            check($sformatf("fade%0d.fading", f + 1), int'(vif.fading), (f < 7) ? 1 : 0);
        end

        // Revert during fade-out
        change_mode(3'b001);
        vif.gfx_mode = 3'b011;
        frame();
        check("rev_g3", int'(vif.G_OUT), 191);
        frame();
        check("rev_g2", int'(vif.G_OUT), 127);
        vif.gfx_mode = 3'b001;
        frame();
        check("rev_fadein", int'(vif.G_OUT), 191);
        check("rev_fadein.fading", int'(vif.fading), 1);
        frame();
        check_rgb("rev_idle", 0, 255, 1);
        check("rev_idle.fading", int'(vif.fading), 0);
        check("rev_active", int'(vif.active_mode), 1);

        // Asynchronous reset during fade-in
        vif.gfx_mode = 3'b011;
        for (int f = 0; f < 5; f++) frame();
        check("fi_active", int'(vif.active_mode), 3);
        check("fi_fading", int'(vif.fading), 1);
        check("fi_g1", int'(vif.G_OUT), 63);
        #2 reset_n = 1'b0;
        #1;
        check_rgb("async_reset", 0, 0, 0);
        check("async_reset.active", int'(vif.active_mode), 0);
        check("async_reset.fading", int'(vif.fading), 0);
        tick(1);
        reset_n = 1'b1;
        tick(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
